// File: rtl/multiplier_controller_taint.sv
// Shift-and-add multiplier controller with sticky taint tracking.
// Moore FSM: every output is a registered decode of the next state.
module multiplier_controller_taint #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             start_t,
  input  logic [WIDTH-1:0] multiplierReg,
  input  logic [WIDTH-1:0] multiplierReg_t,
  output logic             rsclear,
  output logic             rsload,
  output logic             rsshr,
  output logic             mrld,
  output logic             mdld,
  output logic             rsclear_t,
  output logic             rsload_t,
  output logic             rsshr_t,
  output logic             mrld_t,
  output logic             mdld_t,
  output logic             busy,
  output logic             done,
  output logic             done_t
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StTest,
    StAdd,
    StShift,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            op_t_q, op_t_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_t_d  = op_t_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StInit;
          op_t_d  = start_t;
        end
      end
      StInit: begin
        cnt_d   = '0;
        state_d = StTest;
      end
      StTest: begin
        // The decision bit's taint must already show in this iteration's ADD/SHIFT.
        op_t_d  = op_t_q | multiplierReg_t[cnt_q];
        state_d = multiplierReg[cnt_q] ? StAdd : StShift;
      end
      StAdd: begin
        state_d = StShift;
      end
      StShift: begin
        if (cnt_q == CntLast) begin
          state_d = StDone;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = StTest;
        end
      end
      StDone: begin
        state_d = StIdle;
        op_t_d  = 1'b0;
      end
      default: begin
        state_d = StIdle;
        op_t_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      op_t_q    <= 1'b0;
      rsclear   <= 1'b0;
      rsload    <= 1'b0;
      rsshr     <= 1'b0;
      mrld      <= 1'b0;
      mdld      <= 1'b0;
      rsclear_t <= 1'b0;
      rsload_t  <= 1'b0;
      rsshr_t   <= 1'b0;
      mrld_t    <= 1'b0;
      mdld_t    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      done_t    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_t_q    <= op_t_d;
      rsclear   <= (state_d == StInit);
      rsload    <= (state_d == StAdd);
      rsshr     <= (state_d == StShift);
      mrld      <= (state_d == StInit);
      mdld      <= (state_d == StInit);
      rsclear_t <= (state_d == StInit) & op_t_d;
      rsload_t  <= (state_d == StAdd) & op_t_d;
      rsshr_t   <= (state_d == StShift) & op_t_d;
      mrld_t    <= (state_d == StInit) & op_t_d;
      mdld_t    <= (state_d == StInit) & op_t_d;
      busy      <= (state_d != StIdle);
      done      <= (state_d == StDone);
      done_t    <= (state_d == StDone) & op_t_d;
    end
  end

endmodule

// File: tb/tb_multiplier_controller_taint.sv
// Self-checking bench: per-cycle output vectors compared against a queue-based
// model built from the multiplier bits, taints and start taint.
module tb_multiplier_controller_taint;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         start_t = 1'b0;
  logic [W-1:0] multiplierReg = '0;
  logic [W-1:0] multiplierReg_t = '0;
  logic rsclear, rsload, rsshr, mrld, mdld;
  logic rsclear_t, rsload_t, rsshr_t, mrld_t, mdld_t;
  logic busy, done, done_t;

  int n_checks = 0;
  int n_fails  = 0;

  logic [12:0] exp_q[$];
  int          sh2_idx;

  always #5 clk = ~clk;

  multiplier_controller_taint #(.WIDTH(W)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .start_t        (start_t),
    .multiplierReg  (multiplierReg),
    .multiplierReg_t(multiplierReg_t),
    .rsclear        (rsclear),
    .rsload         (rsload),
    .rsshr          (rsshr),
    .mrld           (mrld),
    .mdld           (mdld),
    .rsclear_t      (rsclear_t),
    .rsload_t       (rsload_t),
    .rsshr_t        (rsshr_t),
    .mrld_t         (mrld_t),
    .mdld_t         (mdld_t),
    .busy           (busy),
    .done           (done),
    .done_t         (done_t)
  );

  wire [12:0] dut_v = {rsclear, rsload, rsshr, mrld, mdld, busy, done,
                       rsclear_t, rsload_t, rsshr_t, mrld_t, mdld_t, done_t};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [12:0] vec(input bit rc, rl, rs, mr, md, b, d, t);
    return {rc, rl, rs, mr, md, b, d, rc & t, rl & t, rs & t, mr & t, md & t, d & t};
  endfunction

  // Expected per-cycle output sequence, starting with the cycle after the start edge.
  task automatic build(input logic [W-1:0] m, input logic [W-1:0] mt, input bit st);
    bit t = st;
    int sh = 0;
    exp_q.delete();
    exp_q.push_back(vec(1, 0, 0, 1, 1, 1, 0, t));
    for (int i = 0; i < W; i++) begin
      exp_q.push_back(vec(0, 0, 0, 0, 0, 1, 0, t));
      t = t | mt[i];
      if (m[i]) exp_q.push_back(vec(0, 1, 0, 0, 0, 1, 0, t));
      sh++;
      if (sh == 2) sh2_idx = exp_q.size();
      exp_q.push_back(vec(0, 0, 1, 0, 0, 1, 0, t));
    end
    exp_q.push_back(vec(0, 0, 0, 0, 0, 1, 1, t));
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] m, input logic [W-1:0] mt,
                        input bit st, input int pulse_idx, input bit abort, input bit hold);
    int done_at = -1;
    int waited = 0;
    build(m, mt, st);
    multiplierReg   = m;
    multiplierReg_t = mt;
    start   = 1'b1;
    start_t = st;
    @(posedge clk); #1;
    start = hold;
    for (int k = 0; k < exp_q.size(); k++) begin
      chk({tag, "_seq"}, 32'(dut_v), 32'(exp_q[k]));
      if (done && done_at < 0) done_at = k + 1;
      start = hold || (k == pulse_idx);
      if (abort && k == sh2_idx) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk({tag, "_abort"}, 32'(dut_v), 32'd0);
        for (int j = 0; j < 3; j++) begin
          @(posedge clk); #1;
          chk({tag, "_abort_idle"}, 32'(dut_v), 32'd0);
        end
        start = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    chk({tag, "_latency"}, 32'(done_at), 32'(2 + 2 * W + $countones(m)));
    chk({tag, "_idle"}, 32'(dut_v), 32'd0);
    if (hold) begin
      @(posedge clk); #1;
      chk({tag, "_restart"}, 32'(dut_v), 32'(exp_q[0]));
      start = 1'b0;
      while (!done && waited < 40) begin
        @(posedge clk); #1;
        waited++;
      end
      chk({tag, "_restart_done"}, 32'(done), 32'd1);
      @(posedge clk); #1;
    end
    start   = 1'b0;
    start_t = 1'b0;
    for (int j = 0; j < 3; j++) begin
      chk({tag, "_post_idle"}, 32'(dut_v), 32'd0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 32'(dut_v), 32'd0);
    start = 1'b0;
    @(posedge clk); #1;
    chk("reset_hold", 32'(dut_v), 32'd0);
    rst = 1'b0;

    run_op("m0101", 4'b0101, 4'b0000, 1'b0, -1, 1'b0, 1'b0);
    run_op("m0000", 4'b0000, 4'b0000, 1'b0, -1, 1'b0, 1'b0);
    run_op("m0010_t", 4'b0010, 4'b0010, 1'b0, -1, 1'b0, 1'b0);
    run_op("start_t", 4'b1001, 4'b0000, 1'b1, -1, 1'b0, 1'b0);
    run_op("busy_start", 4'b0101, 4'b0000, 1'b0, 2, 1'b0, 1'b0);
    run_op("abort", 4'b1111, 4'b0100, 1'b1, -1, 1'b1, 1'b0);
    run_op("after_abort", 4'b1010, 4'b0000, 1'b0, -1, 1'b0, 1'b0);
    run_op("hold_start", 4'b0110, 4'b1000, 1'b0, -1, 1'b0, 1'b1);

    for (int r = 0; r < 20; r++) begin
      run_op("rand", W'($urandom), W'($urandom & $urandom), 1'($urandom_range(0, 3) == 0),
             -1, 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/multiplier_controller_taint.md
MULTIPLIER_CONTROLLER_TAINT -- requirements
Module: multiplier_controller_taint

Parameters
REQ-001 SHALL provide WIDTH, default 4, the operand width; it SHALL match the datapath WIDTH.

Interface
REQ-002 SHALL provide clk  input  1  rising-edge clock, the only clock.
REQ-003 SHALL provide rst  input  1  synchronous active-high reset, sampled on the clk rising edge.
REQ-004 SHALL provide start  input  1  request to begin one multiplication.
REQ-005 SHALL provide start_t  input  1  taint of start.
REQ-006 SHALL provide multiplierReg  input  WIDTH  multiplier register value from the datapath.
REQ-007 SHALL provide multiplierReg_t  input  WIDTH  per-bit taint of multiplierReg.
REQ-008 SHALL provide rsclear, rsload, rsshr, mrld, mdld  output  1 each  datapath control strobes.
REQ-009 SHALL provide rsclear_t, rsload_t, rsshr_t, mrld_t, mdld_t  output  1 each  taint of each strobe.
REQ-010 SHALL provide busy  output  1  high in every state except IDLE.
REQ-011 SHALL provide done  output  1  one-cycle pulse, product valid.
REQ-012 SHALL provide done_t  output  1  taint of done.

Function
REQ-013 SHALL implement a registered FSM with states IDLE, INIT, TEST, ADD, SHIFT and DONE; all outputs SHALL be decoded from the registered state only (Moore).
REQ-014 IDLE: start=1 SHALL go to INIT; otherwise the FSM SHALL stay in IDLE.
REQ-015 INIT: SHALL assert rsclear, mrld and mdld for one cycle, clear bit counter cnt to 0, then go to TEST.
REQ-016 TEST: SHALL assert no strobes; multiplierReg[cnt]=1 SHALL go to ADD, otherwise SHIFT.
REQ-017 ADD: SHALL assert rsload for one cycle, then go to SHIFT.
REQ-018 SHALL hold rsload low outside ADD and rsshr low outside SHIFT.
REQ-019 SHIFT: SHALL assert rsshr for one cycle; if cnt=WIDTH-1, SHALL go to DONE, else cnt SHALL increment and the FSM SHALL go to TEST.
REQ-020 DONE: SHALL assert done for one cycle, then go to IDLE.
REQ-021 cnt SHALL be ceil(log2(WIDTH)) bits and SHALL never exceed WIDTH-1; there is no wrap-around within an operation.
REQ-022 Latency: the count from the start-sampling edge to the done cycle SHALL be 2 + 2*WIDTH + popcount(multiplier) cycles; for multiplier=0 and WIDTH=4 this is 10.
REQ-023 start while busy SHALL be ignored (not queued).
REQ-024 start held high through DONE SHALL begin a new operation only after returning to IDLE, so there is at least one IDLE cycle between operations.
REQ-025 SHALL keep a sticky taint bit op_t; in IDLE, op_t SHALL load start_t on the edge that accepts start.
REQ-026 op_t SHALL be ORed with multiplierReg_t[cnt] on every TEST-state edge.
REQ-027 op_t SHALL be cleared on entry to IDLE.
REQ-028 Each *_t strobe output SHALL equal op_t while its strobe state is active and 0 otherwise; done_t SHALL equal op_t in DONE and 0 otherwise.
REQ-029 A tainted decision bit SHALL taint the TEST->ADD/SHIFT decision, so ADD or SHIFT in the same iteration SHALL already show taint.
REQ-030 Taint SHALL never be cleared mid-operation.

Reset
REQ-031 rst=1 SHALL force, on the next edge: state=IDLE, cnt=0, op_t=0, all strobes, busy, done and all *_t outputs 0.
REQ-032 Reset SHALL override start and abort any in-progress operation with no done pulse.
REQ-033 The first start SHALL be accepted on the first edge after rst deasserts.

Verification
REQ-034 Scenario: WIDTH=4, multiplier=0101, start pulse, no taint -> INIT, then TEST,ADD,SHIFT,TEST,SHIFT,TEST,ADD,SHIFT,TEST,SHIFT; done high exactly 12 cycles after the start edge; all *_t=0.
REQ-035 Scenario: multiplier=0000 -> no rsload ever; exactly four rsshr; done 10 cycles after start.
REQ-036 Scenario: multiplier=0010, multiplierReg_t=0010 -> bit-0 iteration untainted; rsload_t=1 in the bit-1 ADD; rsshr_t=1 for bits 1..3; done_t=1; taints 0 after IDLE.
REQ-037 Scenario: start_t=1 with start -> mrld_t=mdld_t=rsclear_t=1 in INIT; done_t=1.
REQ-038 Scenario: start pulsed during ADD -> ignored; exactly one done; the next start is accepted only from IDLE.
REQ-039 Scenario: rst asserted in the second SHIFT -> next cycle IDLE with all outputs 0 and no done; a new start then completes normally.
